// File: rtl/seq_ser_tx_pkg.sv
// Shared types for the serializer feeding the serial sequence detector.
// State encodings match the detector's state constants; 2'd3 is unused and recovers to S_IDLE.
package seq_ser_tx_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } seq_state_e;

  localparam int GAP_CW = 4;
endpackage

// File: rtl/seq_bit_cnt.sv
// Loadable down-counter that saturates at zero; tc flags count==0.
module seq_bit_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - CW'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/seq_ser_tx.sv
// Parallel-in/serial-out stage: takes W-bit words on valid/ready and shifts them out
// one bit per clock on x, resting at IDLE_BIT between words.
module seq_ser_tx
  import seq_ser_tx_pkg::*;
#(
  parameter int   W         = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0,
  parameter int   GAP       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         x,
  output logic         x_valid,
  output logic         busy,
  output logic         word_done
);
  localparam int               CW     = $clog2(W);
  localparam logic [CW-1:0]    BIT_LD = CW'(W-1);
  localparam logic [GAP_CW-1:0] GAP_LD = (GAP > 0) ? GAP_CW'(GAP-1) : '0;

  seq_state_e   state, state_n;
  logic [W-1:0] sreg, sreg_n;
  logic         x_n, xv_n, rdy;
  logic         bit_load, bit_en, bit_tc;
  logic         gap_load, gap_en, gap_tc;

  // sreg holds only the bits not yet on x; the head bit goes straight to x on load
  logic         din_head, sreg_head;
  logic [W-1:0] din_rest, sreg_rest;
  assign din_head  = MSB_FIRST ? din[W-1]  : din[0];
  assign sreg_head = MSB_FIRST ? sreg[W-1] : sreg[0];
  assign din_rest  = MSB_FIRST ? {din[W-2:0], 1'b0}  : {1'b0, din[W-1:1]};
  assign sreg_rest = MSB_FIRST ? {sreg[W-2:0], 1'b0} : {1'b0, sreg[W-1:1]};

  seq_bit_cnt #(.CW(CW)) u_bit_cnt (
    .clk(clk), .reset(reset), .load(bit_load), .load_val(BIT_LD), .en(bit_en), .tc(bit_tc)
  );

  seq_bit_cnt #(.CW(GAP_CW)) u_gap_cnt (
    .clk(clk), .reset(reset), .load(gap_load), .load_val(GAP_LD), .en(gap_en), .tc(gap_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    x_n      = IDLE_BIT;
    xv_n     = 1'b0;
    rdy      = 1'b0;
    bit_load = 1'b0;
    bit_en   = 1'b0;
    gap_load = 1'b0;
    gap_en   = 1'b0;
    case (state)
      S_IDLE: rdy = 1'b1;
      S_SHIFT: begin
        if (!bit_tc) begin
          x_n    = sreg_head;
          xv_n   = 1'b1;
          sreg_n = sreg_rest;
          bit_en = 1'b1;
        end else if (GAP == 0) begin
          rdy     = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n  = S_GAP;
          gap_load = 1'b1;
        end
      end
      S_GAP: begin
        gap_en = 1'b1;
        if (gap_tc) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // an accepted word overrides whatever the state chose, giving back-to-back words when GAP==0
    if (rdy && din_valid) begin
      state_n  = S_SHIFT;
      sreg_n   = din_rest;
      x_n      = din_head;
      xv_n     = 1'b1;
      bit_load = 1'b1;
      gap_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      sreg    <= sreg_n;
      x       <= x_n;
      x_valid <= xv_n;
      busy    <= (state_n != S_IDLE);
    end
  end

  assign din_ready = rdy & ~reset;
  // state and count are both registered, so this lines up with the last bit on x
  assign word_done = (state == S_SHIFT) && bit_tc;
endmodule
